// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Imported by the loader FSM and its byte assembler.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_WORD,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Places incoming bytes little-endian into a 32-bit word.
// Counts bytes held and flags a complete word.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        wr_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [31:0] word_nxt,
  output logic [2:0]  byte_cnt,
  output logic        word_full
);

  logic [31:0] word_q, word_d;
  logic [2:0]  cnt_q, cnt_d;

  assign word_full = (cnt_q == 3'(BYTES_PER_WORD));

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (wr_en && !word_full) begin
      word_d[{cnt_q[1:0], 3'b000} +: 8] = byte_in;
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word     = word_q;
  assign word_nxt = word_d;
  assign byte_cnt = cnt_q;

endmodule

// File: rtl/inst_loader.sv
// Program loader: turns a byte stream into sequential inst_mem writes
// and holds the core in reset until the whole image has landed.
module inst_loader
  import loader_pkg::*;
#(
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 80,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_adr,
  output logic [INST_WIDTH-1:0] mem_wr_data,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  err
);

  localparam int CW = $clog2(DEPTH + 1);

  state_e                state_q, state_d;
  logic [15:0]           n_words_q, n_words_d;
  logic [CW-1:0]         word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [INST_WIDTH-1:0] data_q, data_d;

  logic        asm_clr;
  logic        asm_wr;
  logic [31:0] asm_word;
  logic [31:0] asm_word_nxt;
  logic [2:0]  asm_cnt;
  logic        asm_full;
  logic [15:0] hdr_n;

  byte_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (asm_clr),
    .wr_en     (asm_wr),
    .byte_in   (in_data),
    .word      (asm_word),
    .word_nxt  (asm_word_nxt),
    .byte_cnt  (asm_cnt),
    .word_full (asm_full)
  );

  assign hdr_n  = {in_data, n_words_q[7:0]};
  assign asm_wr = in_valid && (state_q == ST_WORD);

  always_comb begin
    state_d    = state_q;
    n_words_d  = n_words_q;
    word_cnt_d = word_cnt_q;
    adr_d      = adr_q;
    data_d     = data_q;
    in_ready   = 1'b0;
    mem_wr_en  = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    asm_clr    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_HDR0;
      end
      ST_HDR0: begin
        in_ready = 1'b1;
        if (in_valid) begin
          n_words_d[7:0] = in_data;
          state_d        = ST_HDR1;
        end
      end
      ST_HDR1: begin
        in_ready = 1'b1;
        if (in_valid) begin
          n_words_d[15:8] = in_data;
          word_cnt_d      = '0;
          asm_clr         = 1'b1;
          if (hdr_n == 16'd0)             state_d = ST_DONE;
          else if (hdr_n > 16'(DEPTH))    state_d = ST_ERR;
          else                            state_d = ST_WORD;
        end
      end
      ST_WORD: begin
        in_ready = 1'b1;
        // Latch address and word on the last byte so they hold after WRITE
        if (in_valid && asm_cnt == 3'(BYTES_PER_WORD - 1)) begin
          adr_d   = ADDR_WIDTH'(word_cnt_q);
          data_d  = INST_WIDTH'(asm_word_nxt);
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_wr_en  = 1'b1;
        asm_clr    = 1'b1;
        word_cnt_d = word_cnt_q + CW'(1);
        if (16'(word_cnt_d) == n_words_q) state_d = ST_DONE;
        else                              state_d = ST_WORD;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_d = ST_HDR0;
      end
      ST_ERR: begin
        err = 1'b1;
        if (start) state_d = ST_HDR0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      n_words_q  <= '0;
      word_cnt_q <= '0;
      adr_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      n_words_q  <= n_words_d;
      word_cnt_q <= word_cnt_d;
      adr_q      <= adr_d;
      data_q     <= data_d;
    end
  end

  assign mem_wr_adr  = adr_q;
  assign mem_wr_data = data_q;
  assign cpu_rst     = rst || (state_q != ST_DONE);

endmodule
